// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: request/response bundle between the control unit and the
// iterative RV32M multiply/divide unit.
interface alu_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, op, a, b, input busy, done, result);
  modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M multiply/divide unit, one bit per cycle.
// Multiply is shift-add on operand magnitudes, divide is restoring; the sign
// of the final value is fixed up when the last iteration completes.
// Optional build macro MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow
// and zero operands skip the iteration and finish one cycle after accept.
module alu_muldiv #(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         reset,
  alu_muldiv_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_n;
  logic            accept;
  logic            early;
  logic [2:0]      op_q;
  logic            sa_q, sb_q, dz_q;
  logic [XLEN-1:0] mag_a_q, mag_b_q;
  logic [XLEN-1:0] hi_q, lo_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] result_q;

  logic            sa_in, sb_in;
  logic [XLEN-1:0] mag_a_in, mag_b_in;
  logic            last;
  logic [XLEN:0]   mul_sum, div_sh, div_diff;
  logic [XLEN-1:0] hi_step, lo_step;

  // Two's-complement magnitude of v when neg is set.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Apply RISC-V sign rules to the raw magnitude result and pick the half/word.
  function automatic logic [XLEN-1:0] finalize(input logic [2:0] op, input logic sa,
                                               input logic sb, input logic dz,
                                               input logic [XLEN-1:0] hi,
                                               input logic [XLEN-1:0] lo);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    if (op[2]) begin
      quo = dz ? '1 : ((sa ^ sb) ? -lo : lo);
      rem = sa ? -hi : hi;
      return op[1] ? rem : quo;
    end
    prod = {hi, lo};
    if (sa ^ sb) prod = -prod;
    return (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction

`ifdef MULDIV_EARLY_OUT_EN
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic ovf_in, take_early;

  // Result of a case that needs no iteration (only valid when take_early).
  function automatic logic [XLEN-1:0] early_result(input logic [2:0] op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b,
                                                   input logic ovf);
    if (op[2]) begin
      if (b == '0) return op[1] ? a : '1;
      if (ovf)     return op[1] ? '0 : a;
    end
    return '0;
  endfunction

  assign ovf_in     = bus.op[2] && !bus.op[0] && (bus.a == MOST_NEG) && (bus.b == '1);
  assign take_early = (bus.a == '0) || (bus.b == '0) || (bus.op[2] && ovf_in);
`endif

  // Operand sign detection: MUL is treated as unsigned, MULHSU signs a only.
  assign sa_in    = bus.a[XLEN-1] && (bus.op == OP_MULH || bus.op == OP_MULHSU ||
                                      bus.op == OP_DIV  || bus.op == OP_REM);
  assign sb_in    = bus.b[XLEN-1] && (bus.op == OP_MULH || bus.op == OP_DIV ||
                                      bus.op == OP_REM);
  assign mag_a_in = magnitude(bus.a, sa_in);
  assign mag_b_in = magnitude(bus.b, sb_in);
  assign last     = (cnt_q == CNT_W'(XLEN - 1));

  // One iteration: {hi,lo} is the product register or remainder/quotient pair.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_a_q} : '0);
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, mag_b_q};
    if (op_q[2]) begin
      hi_step = div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
      lo_step = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      hi_step = mul_sum[XLEN:1];
      lo_step = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and accept decode; start is only looked at in IDLE or DONE.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    early   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_n = CALC;
`ifdef MULDIV_EARLY_OUT_EN
          if (take_early) begin
            early   = 1'b1;
            state_n = DONE;
          end
`endif
        end else begin
          state_n = IDLE;
        end
      end
      CALC:    if (last) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // Operand latch on accept, iteration in CALC, result load entering DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q    <= bus.op;
      sa_q    <= sa_in;
      sb_q    <= sb_in;
      dz_q    <= bus.op[2] && (bus.b == '0);
      mag_a_q <= mag_a_in;
      mag_b_q <= mag_b_in;
      hi_q    <= '0;
      lo_q    <= bus.op[2] ? mag_a_in : mag_b_in;
      cnt_q   <= '0;
`ifdef MULDIV_EARLY_OUT_EN
      if (early) result_q <= early_result(bus.op, bus.a, bus.b, ovf_in);
`endif
    end else if (state == CALC) begin
      hi_q  <= hi_step;
      lo_q  <= lo_step;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last) result_q <= finalize(op_q, sa_q, sb_q, dz_q, hi_step, lo_step);
    end
  end

  assign bus.busy   = (state == CALC);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vectors with hand-computed results for alu_muldiv.
module tb_alu_muldiv;
  localparam int XLEN = 32;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_muldiv_if #(.XLEN(XLEN)) bus ();

  alu_muldiv #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for done. special marks cases that
  // finish right after accept when the early-out build is used. glitch pulses
  // start during the iteration, which must be ignored.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input bit special, input bit glitch);
    int k;
    int busy_n;
    int exp_k;
    bit early;
    early = special;
`ifndef MULDIV_EARLY_OUT_EN
    early = 1'b0;
`endif
    exp_k     = early ? 0 : XLEN;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = MUL;
    bus.a     = '1;
    bus.b     = '1;
    k      = 0;
    busy_n = 0;
    while (!bus.done && k < 40) begin
      if (bus.busy) busy_n++;
      bus.start = (glitch && k == 5);
      @(posedge clk); #1;
      k++;
    end
    bus.start = 1'b0;
    check_val({tag, " latency"}, 32'(k), 32'(exp_k));
    check_val({tag, " busy cycles"}, 32'(busy_n), 32'(exp_k));
    check_val({tag, " result"}, bus.result, exp);
  endtask

  initial begin
    int done_seen;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset busy", 32'(bus.busy), 32'd0);
    check_val("reset done", 32'(bus.done), 32'd0);
    check_val("reset result", bus.result, 32'd0);
    reset = 1'b0;

    // Consecutive calls are back-to-back: each start is raised while done=1.
    run_op("MUL 7*-3",        MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b0);
    run_op("MULH min*min",    MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b0);
    run_op("MULHU max*max",   MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_op("MULHSU -1*2",     MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, 1'b0);
    run_op("MULHU max*2",     MULHU,  32'hFFFFFFFF, 32'd2,        32'h00000001, 1'b0, 1'b0);
    run_op("DIV -7/2",        DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("REM -7/2",        REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 1'b0);
    run_op("DIVU 5/0",        DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1'b0);
    run_op("REMU 5/0",        REMU,   32'd5,        32'd0,        32'd5,        1'b1, 1'b0);
    run_op("DIV ovf",         DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0);
    run_op("REM ovf",         REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b0);
    run_op("DIV 7/0",         DIV,    32'd7,        32'd0,        32'hFFFFFFFF, 1'b1, 1'b0);
    run_op("REM -7/0",        REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b1, 1'b0);
    run_op("MUL 0*5",         MUL,    32'd0,        32'd5,        32'd0,        1'b1, 1'b0);
    run_op("DIVU 100/7",      DIVU,   32'd100,      32'd7,        32'd14,       1'b0, 1'b0);
    run_op("REMU 100/7",      REMU,   32'd100,      32'd7,        32'd2,        1'b0, 1'b0);
    run_op("REM 7/-2",        REM,    32'd7,        32'hFFFFFFFE, 32'd1,        1'b0, 1'b0);
    run_op("DIV 7/-2",        DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0);

    // Abandon a DIVU with reset (start also high) in its 10th CALC cycle.
    bus.start = 1'b1;
    bus.op    = DIVU;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check_val("pre-reset busy", 32'(bus.busy), 32'd1);
    reset     = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    check_val("mid reset busy", 32'(bus.busy), 32'd0);
    check_val("mid reset done", 32'(bus.done), 32'd0);
    check_val("mid reset result", bus.result, 32'd0);
    reset     = 1'b0;
    bus.start = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) done_seen++;
    end
    check_val("abandoned op silent", 32'(done_seen), 32'd0);

    run_op("DIVU after reset", DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_val("done one cycle", 32'(bus.done), 32'd0);
    check_val("result held", bus.result, 32'd14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Parametrised iterative multiply/divide unit for the RV32M extension. It is the multi-cycle successor to the combinational datapath ALU. It sits beside the ALU in the datapath: the control unit pulses start with funct3 and both register-file operands, stalls the PC while busy, and writes result back on done. Width is generic in XLEN; multiply uses a shift-add algorithm and divide uses a restoring algorithm, one bit per cycle.

Parameters:
XLEN, 32, operand/result width in bits (must be >= 2)
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE
op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  input  XLEN  rs1 operand
b  input  XLEN  rs2 operand
busy  output  1  high while iterating (CALC)
done  output  1  one-cycle pulse; result valid
result  output  XLEN  registered result; held until next accepted start

Behaviour:
- Reset: synchronous; state=IDLE, busy=0, done=0, result=0, all internal accumulators/counter=0.
- FSM states:
  - IDLE -> CALC on start.
  - CALC -> DONE when counter reaches XLEN.
  - DONE -> CALC on start, else IDLE.
- Accept (edge where start=1 in IDLE/DONE):
  - latch op, sign flags and |a|, |b|; counter=0.
  - Signed ops: MULH takes both operands signed; MULHSU signs a only; DIV/REM sign both; MUL treated unsigned (low half is sign-independent).
- CALC: one iteration per cycle, XLEN cycles; busy=1; start ignored; op/a/b changes ignored.
- Latency: start sampled at edge E0 -> busy=1 for cycles after E0..E0+XLEN -> done=1 for exactly one cycle after edge E0+XLEN. With XLEN=32, done is visible in the 33rd cycle after the accepting edge.
- result is loaded on the edge entering DONE and held through IDLE.
- Back-to-back: start high while done=1 is accepted; done deasserts next cycle, busy=1.
- Multiply:
  - 2*XLEN product of magnitudes; negate if the result sign flag is set.
  - MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits.
- Divide (restoring):
  - quotient sign = sa^sb; remainder sign = sa (RISC-V truncation rules).
- Division by zero (b==0), no trap:
  - DIV/DIVU quotient = all ones.
  - REM/REMU = a.
- Signed overflow (DIV/REM, a = most-negative, b = -1):
  - quotient = a.
  - remainder = 0.
- Special cases still take the full XLEN-cycle latency unless the optional feature is enabled.
- Reset mid-operation: FSM returns to IDLE on that edge, result=0, no done pulse for the abandoned op.
- start and reset both high: reset wins.
- All arithmetic is modulo 2^XLEN on result; no x outputs in any state.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: on accept, divide-by-zero, signed overflow, and any op with a==0 or b==0 skip CALC. The FSM goes straight to DONE, so done pulses on the cycle after the accepting edge (latency 1) and busy never rises.
- Undefined: every op takes the fixed XLEN+1 latency; results are identical either way.

Test Plan:
- MUL a=7, b=0xFFFFFFFD -> busy for 32 cycles, done pulse in cycle 33, result=0xFFFFFFEB.
- MULH a=b=0x80000000 -> 0x40000000.
- MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD.
- REM same operands -> 0xFFFFFFFF; back-to-back start during done accepted with no idle cycle.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
  - With MULDIV_EARLY_OUT_EN, each of these returns done 1 cycle after accept.
- Start DIVU 100/7, assert reset at CALC cycle 10 -> next cycle busy=0, result=0, no done pulse.
  - start pulses during CALC are ignored; a new start after reset gives quotient 14 on schedule.
